// File: rtl/bnn_pkg.sv
// Package shared by the class voter and its argmax.
// Holds the class count, the class-index width and the two-state
// decision FSM encoding.
package bnn_pkg;
  localparam int NUM_CLASSES = 4;
  localparam int CLS_W       = 2;

  // ST_EMPTY: no decision held (out_valid=0)
  // ST_FULL : a decision is held (out_valid=1)
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/bnn_class_voter_if.sv
// Bundle of all non-clock/reset signals of the class voter.
//
// Handshake: the input side has no backpressure; a sample is taken on
// every rising edge with in_valid=1 and clear=0. The output side is a
// valid/ready pair: a decision is transferred on a rising edge where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0 the
// result fields hold steady unless a new window closes (overrun).
//
// master : sample source / decision consumer
// slave  : the voter itself
interface bnn_class_voter_if
  import bnn_pkg::*;
#(
  parameter int CNT_W = 4
);
  logic                   in_valid;
  logic [NUM_CLASSES-1:0] in_bits;
  logic                   clear;
  logic                   out_valid;
  logic                   out_ready;
  logic [CLS_W-1:0]       out_class;
  logic [CNT_W-1:0]       out_score;
  logic                   out_tie;
  logic                   out_none;
  logic                   overrun;
  state_e                 state_dbg;

  modport master (
    output in_valid, in_bits, clear, out_ready,
    input  out_valid, out_class, out_score, out_tie, out_none, overrun,
           state_dbg
  );

  modport slave (
    input  in_valid, in_bits, clear, out_ready,
    output out_valid, out_class, out_score, out_tie, out_none, overrun,
           state_dbg
  );
endinterface

// File: rtl/bnn_argmax4.sv
// Purely combinational argmax over four class counts.
// Ports:
//   cnt0..cnt3 : per-class vote counts
//   idx        : index of the highest count, lowest index on a tie
//   score      : the winning count
//   tie        : two or more classes share a nonzero maximum
//   none       : every count is zero (idx and score are then 0)
module bnn_argmax4
  import bnn_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  input  logic [CNT_W-1:0] cnt2,
  input  logic [CNT_W-1:0] cnt3,
  output logic [CLS_W-1:0] idx,
  output logic [CNT_W-1:0] score,
  output logic             tie,
  output logic             none
);
  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;
  logic [2:0]                        n_max;

  assign cnt = {cnt3, cnt2, cnt1, cnt0};

  always_comb begin
    idx   = '0;
    score = cnt[0];
    n_max = '0;
    // Strict '>' keeps the lowest index on equal counts.
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (cnt[k] > score) begin
        idx   = CLS_W'(k);
        score = cnt[k];
      end
    end
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (cnt[k] == score) n_max = n_max + 3'd1;
    end
    none = (score == '0);
    tie  = !none && (n_max > 3'd1);
  end
endmodule

// File: rtl/bnn_class_voter.sv
// Accumulates per-class votes from a binary neural network output layer
// over WINDOW accepted samples, then registers the argmax decision.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of bnn_class_voter_if (samples in, decision out,
//           sticky overrun flag, FSM state for observation)
module bnn_class_voter
  import bnn_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  bnn_class_voter_if.slave    bus
);
  localparam int              SCNT_W = 4;
  localparam logic [SCNT_W-1:0] LAST = SCNT_W'(WINDOW - 1);

  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
  state_e            state_q, state_d;
  logic [CLS_W-1:0]  class_q, class_d;
  logic [CNT_W-1:0]  score_q, score_d;
  logic              tie_q, tie_d;
  logic              none_q, none_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              close;
  logic [CLS_W-1:0]  am_idx;
  logic [CNT_W-1:0]  am_score;
  logic              am_tie;
  logic              am_none;

  assign accept = bus.in_valid && !bus.clear;
  assign close  = accept && (sample_cnt_q == LAST);

  // Saturating per-class increment including the current sample.
  always_comb begin
    cnt_inc = cnt_q;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (bus.in_bits[k] && (cnt_q[k] != {CNT_W{1'b1}}))
        cnt_inc[k] = cnt_q[k] + 1'b1;
    end
  end

  // The decision on a closing edge must see the closing sample's votes.
  bnn_argmax4 #(.CNT_W(CNT_W)) u_argmax (
    .cnt0  (cnt_inc[0]),
    .cnt1  (cnt_inc[1]),
    .cnt2  (cnt_inc[2]),
    .cnt3  (cnt_inc[3]),
    .idx   (am_idx),
    .score (am_score),
    .tie   (am_tie),
    .none  (am_none)
  );

  // Accumulator / window counter.
  always_comb begin
    cnt_d        = cnt_q;
    sample_cnt_d = sample_cnt_q;
    if (bus.clear || close) begin
      cnt_d        = '0;
      sample_cnt_d = '0;
    end else if (accept) begin
      cnt_d        = cnt_inc;
      sample_cnt_d = sample_cnt_q + 1'b1;
    end
  end

  // Decision FSM and result registers.
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    score_d   = score_q;
    tie_d     = tie_q;
    none_d    = none_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_EMPTY: if (close) state_d = ST_FULL;
      ST_FULL: begin
        if (close) begin
          state_d = ST_FULL;
          // Only an unconsumed decision being replaced counts as overrun.
          if (!bus.out_ready) overrun_d = 1'b1;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (close) begin
      class_d = am_idx;
      score_d = am_score;
      tie_d   = am_tie;
      none_d  = am_none;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sample_cnt_q <= '0;
      state_q      <= ST_EMPTY;
      class_q      <= '0;
      score_q      <= '0;
      tie_q        <= 1'b0;
      none_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sample_cnt_q <= sample_cnt_d;
      state_q      <= state_d;
      class_q      <= class_d;
      score_q      <= score_d;
      tie_q        <= tie_d;
      none_q       <= none_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_class = class_q;
  assign bus.out_score = score_q;
  assign bus.out_tie   = tie_q;
  assign bus.out_none  = none_q;
  assign bus.overrun   = overrun_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_bnn_class_voter.sv
// Directed bench for bnn_class_voter with WINDOW=8, CNT_W=4.
module tb_bnn_class_voter;
  import bnn_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bnn_class_voter_if #(.CNT_W(4)) bus ();

  bnn_class_voter #(.WINDOW(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply inputs, let one rising edge pass, settle 1 time unit.
  task automatic step(input logic v, input logic [3:0] b, input logic c,
                      input logic r);
    bus.in_valid  = v;
    bus.in_bits   = b;
    bus.clear     = c;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input int n, input logic [3:0] b, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, b, 1'b0, r);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 4'b0000, 1'b0, r);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [31:0] v,
                            input logic [31:0] cls, input logic [31:0] sc,
                            input logic [31:0] t, input logic [31:0] nn);
    chk({tag, "_valid"}, 32'(bus.out_valid), v);
    chk({tag, "_class"}, 32'(bus.out_class), cls);
    chk({tag, "_score"}, 32'(bus.out_score), sc);
    chk({tag, "_tie"},   32'(bus.out_tie),   t);
    chk({tag, "_none"},  32'(bus.out_none),  nn);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = 4'b0000;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk_result("rst", 0, 0, 0, 0, 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_state", 32'(bus.state_dbg), 32'(ST_EMPTY));
    reset = 1'b0;
    idle(1'b0);

    // Single class, plus latency and hold while not ready
    samples(7, 4'b0100, 1'b0);
    chk("c2_latency_valid", 32'(bus.out_valid), 0);
    samples(1, 4'b0100, 1'b0);
    chk_result("c2", 1, 2, 8, 0, 0);
    chk("c2_state", 32'(bus.state_dbg), 32'(ST_FULL));
    idle(1'b0);
    idle(1'b0);
    chk_result("c2_hold", 1, 2, 8, 0, 0);
    idle(1'b1);
    chk("c2_consumed_valid", 32'(bus.out_valid), 0);

    // Tie between class 0 and class 3: lowest index wins
    samples(4, 4'b0001, 1'b0);
    samples(4, 4'b1000, 1'b0);
    chk_result("tie", 1, 0, 4, 1, 0);
    idle(1'b1);

    // No votes at all
    samples(8, 4'b0000, 1'b0);
    chk_result("none", 1, 0, 0, 0, 1);
    idle(1'b1);

    // Close on the same edge as consumption: stays valid, no overrun
    samples(8, 4'b0001, 1'b0);
    chk_result("b2b_first", 1, 0, 8, 0, 0);
    samples(7, 4'b0010, 1'b0);
    samples(1, 4'b0010, 1'b1);
    chk_result("b2b_second", 1, 1, 8, 0, 0);
    chk("b2b_overrun", 32'(bus.overrun), 0);
    idle(1'b1);
    chk("b2b_consumed_valid", 32'(bus.out_valid), 0);

    // Clear drops the partial window and the simultaneous sample
    samples(5, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    samples(7, 4'b0100, 1'b0);
    chk("clr_no_early_valid", 32'(bus.out_valid), 0);
    samples(1, 4'b0100, 1'b0);
    chk_result("clr", 1, 2, 8, 0, 0);
    idle(1'b1);

    // Overrun: two closes without consumption
    samples(8, 4'b0010, 1'b0);
    chk("ovr_first_flag", 32'(bus.overrun), 0);
    samples(8, 4'b0010, 1'b0);
    chk_result("ovr", 1, 1, 8, 0, 0);
    chk("ovr_flag", 32'(bus.overrun), 1);
    idle(1'b1);
    chk("ovr_consumed_valid", 32'(bus.out_valid), 0);
    chk("ovr_sticky", 32'(bus.overrun), 1);

    // Clear does not disturb a held decision
    samples(8, 4'b1000, 1'b0);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    chk_result("clr_hold", 1, 3, 8, 0, 0);
    idle(1'b1);

    // Reset mid-window, with a sample presented during reset
    samples(3, 4'b0001, 1'b0);
    reset = 1'b1;
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    reset = 1'b0;
    chk_result("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst_overrun", 32'(bus.overrun), 0);
    samples(7, 4'b1000, 1'b0);
    chk("mid_rst_no_early_valid", 32'(bus.out_valid), 0);
    samples(1, 4'b1000, 1'b0);
    chk_result("mid_rst_win", 1, 3, 8, 0, 0);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bnn_class_voter.md
BNN_CLASS_VOTER -- requirements
Module: bnn_class_voter

Interface
REQ-001 Parameter WINDOW, default 8, gives the number of accepted samples per decision; the legal range is 1..15.
REQ-002 Parameter CNT_W, default 4, gives the per-class counter width; it SHALL satisfy 2^CNT_W-1 >= WINDOW.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  a sample is presented this cycle.
REQ-006 in_bits  in  4  registered output-layer neuron bits; bit k is a vote for class k.
REQ-007 clear  in  1  synchronous abort of the current window.
REQ-008 out_valid  out  1  a decision is held and awaiting consumption.
REQ-009 out_ready  in  1  the consumer accepts the decision this cycle.
REQ-010 out_class  out  2  index of the winning class.
REQ-011 out_score  out  CNT_W  vote count of the winning class.
REQ-012 out_tie  out  1  two or more classes share the maximum, nonzero count.
REQ-013 out_none  out  1  every class count is zero.
REQ-014 overrun  out  1  sticky flag: an unconsumed decision was overwritten.

Function
REQ-015 The block SHALL always accept input (no backpressure); a sample is accepted when in_valid=1 and clear=0.
REQ-016 Each accepted sample SHALL add in_bits[k] to count[k], saturating at 2^CNT_W-1, and SHALL increment sample_cnt.
REQ-017 The accepted sample with sample_cnt==WINDOW-1 closes the window.
REQ-018 On that closing edge the block SHALL, in one step:
  - compute argmax over the counts including that sample;
  - register out_class, out_score, out_tie and out_none;
  - set out_valid=1;
  - zero all counts and sample_cnt.
  There is no dead cycle: the next cycle's sample begins a new window.
REQ-019 Latency: out_valid SHALL rise in the cycle after the WINDOW-th accepted sample.
REQ-020 Argmax: the highest count wins; on a tie the lowest index wins; out_score is the winning count.
REQ-021 If all counts are zero, the block SHALL output out_class=0, out_score=0, out_none=1 and out_tie=0.
REQ-022 out_valid and the result fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 out_valid SHALL fall after an edge where out_valid=1 and out_ready=1, unless a new window closes on that same edge; in that case out_valid stays 1, the new result loads, and overrun is not set.
REQ-024 If a window closes while out_valid=1 and out_ready=0, the new result SHALL overwrite the old one and overrun SHALL set; overrun clears only on reset.
REQ-025 clear=1 SHALL zero all counts and sample_cnt and drop any simultaneous sample. It SHALL NOT affect out_valid, the result fields or overrun.
REQ-026 The FSM SHALL have exactly two states:
  - EMPTY (out_valid=0) -> FULL on a window close;
  - FULL -> EMPTY on out_ready with no close;
  - FULL -> FULL on a close, with or without out_ready.

Reset
REQ-027 On reset=1 the block SHALL zero all counts, sample_cnt, out_valid, out_class, out_score, out_tie, out_none and overrun, and enter EMPTY.
REQ-028 Reset SHALL take priority over clear, in_valid and out_ready; a window in progress when reset is applied is discarded.

Structure
REQ-029 A shared package bnn_pkg SHALL hold NUM_CLASSES=4, the class-index width (2) and the FSM state enumeration.
REQ-030 The argmax SHALL be a purely combinational sub-module, bnn_argmax4, taking four counts and returning index, score, tie and none.
REQ-031 All counters and output registers SHALL live in bnn_class_voter.

Verification
REQ-032 WINDOW=8; 8 samples of in_bits=4'b0100 -> one cycle later out_valid=1, out_class=2, out_score=8, out_tie=0, out_none=0.
REQ-033 WINDOW=8; 4x 4'b0001 then 4x 4'b1000 -> out_class=0, out_score=4, out_tie=1.
REQ-034 WINDOW=8; 8x 4'b0000 -> out_class=0, out_score=0, out_none=1, out_tie=0.
REQ-035 Overrun: out_ready=0 for 16 consecutive samples of 4'b0010 -> two window closes, overrun=1, result holds class 1 with score 8. Then out_ready=1 for one cycle -> out_valid=0, and overrun stays 1.
REQ-036 Clear: 5 samples of 4'b0001, then clear together with in_valid, then 8 samples of 4'b0100 -> a single decision, class 2, score 8.
REQ-037 Reset mid-window: after 3 samples, pulse reset -> all outputs 0; the next 8 samples of 4'b1000 -> class 3, score 8.
